// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, CSR offsets and CTRL bit layout.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT,
    ST_RELEASE,
    ST_DONE
  } seq_state_t;

  localparam logic [4:0] CTRL_OFS  = 5'd0;
  localparam logic [4:0] DELAY_OFS = 5'd1;
  localparam logic [4:0] FORCE_OFS = 5'd2;

  localparam int unsigned CTRL_RESTART = 0;
  localparam int unsigned CTRL_BUSY    = 1;
  localparam int unsigned CTRL_STEP_LO = 4;
  localparam int unsigned CTRL_STEP_HI = 6;
  localparam int unsigned CTRL_DONE    = 7;

  function automatic logic [7:0] ctrl_word(input logic busy, input logic [2:0] step,
                                           input logic done);
    logic [7:0] w;
    w = '0;
    w[CTRL_BUSY] = busy;
    w[CTRL_STEP_HI:CTRL_STEP_LO] = step;
    w[CTRL_DONE] = done;
    return w;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// CSR register-bus bundle between the I2C-slave register file (master) and the sequencer (slave).
interface reset_sequencer_if;

  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input csr_do);
  modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);

endinterface

// File: rtl/reset_sequencer_seq_tick_timer.sv
// ce-gated 8-bit step timer shared by the ASSERT and WAIT phases; saturates instead of wrapping.
module seq_tick_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       clear,
  input  logic [7:0] delay,
  output logic       expired
);

  logic [7:0] cnt;

  // Normally the comparison happens on a ce tick; a zero delay, or a delay
  // lowered below the running count, expires without waiting for ce.
  assign expired = (delay == '0) || (cnt > delay) || (ce && (cnt >= delay));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (ce && (cnt < delay)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered peripheral reset release with CSR control. Optional irq port: RESET_SEQUENCER_IRQ_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter logic [4:0]  BASE_ADDR  = 5'h1d,
  parameter int unsigned NUM_RESETS = 6,
  parameter logic [7:0]  DFL_DELAY  = 8'd33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [NUM_RESETS-1:0] hold,
  reset_sequencer_if.slave      csr,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  done
`ifdef RESET_SEQUENCER_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [7:0] FORCE_MASK = 8'((9'd1 << NUM_RESETS) - 9'd1);
  localparam logic [2:0] LAST_STEP  = 3'(NUM_RESETS - 1);

  seq_state_t            state;
  logic [2:0]            step;
  logic [NUM_RESETS-1:0] seq_rst;
  logic [NUM_RESETS-1:0] seq_nxt;
  logic [7:0]            delay_q;
  logic [7:0]            force_q;
  logic [7:0]            force_nxt;
  logic [4:0]            ofs;
  logic                  sel;
  logic                  wr_ctrl;
  logic                  wr_delay;
  logic                  wr_force;
  logic                  trigger;
  logic                  counting;
  logic                  busy;
  logic                  expired;
  logic                  tmr_clear;

  assign ofs      = csr.csr_a - BASE_ADDR;
  assign sel      = (ofs <= FORCE_OFS);
  assign wr_ctrl  = csr.csr_we && sel && (ofs == CTRL_OFS);
  assign wr_delay = csr.csr_we && sel && (ofs == DELAY_OFS);
  assign wr_force = csr.csr_we && sel && (ofs == FORCE_OFS);

  assign trigger   = start || (wr_ctrl && csr.csr_di[CTRL_RESTART]);
  assign counting  = (state == ST_ASSERT) || (state == ST_WAIT);
  assign busy      = counting || (state == ST_RELEASE);
  assign tmr_clear = trigger || !counting || expired;
  assign force_nxt = wr_force ? (csr.csr_di & FORCE_MASK) : force_q;

  seq_tick_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .clear   (tmr_clear),
    .delay   (delay_q),
    .expired (expired)
  );

  // Next sequence mask is computed ahead of the FSM edge so rst_out, which is
  // registered, reflects a transition on the same clk the state changes.
  always_comb begin
    seq_nxt = seq_rst;
    if (trigger) begin
      seq_nxt = '1;
    end else begin
      case (state)
        ST_IDLE, ST_ASSERT: seq_nxt = '1;
        ST_WAIT:            if (expired) seq_nxt[step] = 1'b0;
        ST_DONE:            seq_nxt = '0;
        default:            ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      step    <= '0;
      seq_rst <= '1;
      done    <= 1'b0;
      delay_q <= DFL_DELAY;
      force_q <= '0;
      rst_out <= '1;
    end else begin
      seq_rst <= seq_nxt;
      force_q <= force_nxt;
      rst_out <= seq_nxt | hold | force_nxt[NUM_RESETS-1:0];
      if (wr_delay) delay_q <= csr.csr_di;

      if (trigger) begin
        state <= ST_ASSERT;
        step  <= '0;
        done  <= 1'b0;
      end else begin
        case (state)
          ST_ASSERT: if (expired) state <= ST_WAIT;
          ST_WAIT:   if (expired) state <= ST_RELEASE;
          ST_RELEASE: begin
            if (step == LAST_STEP) begin
              state <= ST_DONE;
              step  <= '0;
              done  <= 1'b1;
            end else begin
              state <= ST_WAIT;
              step  <= step + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RESET_SEQUENCER_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= !trigger && (state == ST_RELEASE) && (step == LAST_STEP);
    end
  end
`endif

  always_comb begin
    csr.csr_do = '0;
    if (sel) begin
      case (ofs)
        CTRL_OFS:  csr.csr_do = ctrl_word(busy, step, done);
        DELAY_OFS: csr.csr_do = delay_q;
        FORCE_OFS: csr.csr_do = force_q;
        default:   ;
      endcase
    end
  end

endmodule
